// File: rtl/serial_tx_fsm.sv
// serial_tx_fsm: Moore FSM frame transmitter (start, LSB-first data, stop).
// Define SERIAL_TX_PARITY_EN to add an even-parity bit before stop.
module serial_tx_fsm #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit;
  logic [CYC_W-1:0]  r_cyc;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_par;
`endif
  logic              w_tx;
  logic              w_ready;
  logic              w_accept;
  logic              w_bit_end;

  assign w_accept  = (r_state == S_IDLE) && valid_in;
  assign w_bit_end = (r_cyc == CYC_LAST);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus Moore outputs decoded from state and registers.
  always_comb begin
    w_next  = S_IDLE;
    w_tx    = 1'b1;
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_next  = valid_in ? S_START : S_IDLE;
      end
      S_START: begin
        w_tx   = 1'b0;
        w_next = w_bit_end ? S_DATA : S_START;
      end
      S_DATA: begin
        w_tx   = r_shift[0];
        w_next = S_DATA;
        if (w_bit_end && (r_bit == BIT_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        w_tx   = r_par;
        w_next = w_bit_end ? S_STOP : S_PARITY;
      end
`endif
      S_STOP: begin
        w_tx   = 1'b1;
        w_next = w_bit_end ? S_IDLE : S_STOP;
      end
      default: begin
        w_tx    = 1'b1;
        w_ready = 1'b1;
        w_next  = S_IDLE;
      end
    endcase
  end

  // Datapath: load word on acceptance, pace bits, shift out data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shift <= data_in;
      r_bit   <= '0;
      r_cyc   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= ^data_in;
`endif
    end else if (!w_ready) begin
      r_cyc <= w_bit_end ? '0 : r_cyc + 1'b1;
      if ((r_state == S_DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  assign tx_out    = w_tx;
  assign ready_out = w_ready;
  assign busy      = !w_ready;

endmodule

// File: tb/tb_serial_tx_fsm.sv
// tb_serial_tx_fsm: scoreboard bench, BIT_CYCLES=4 and BIT_CYCLES=1 DUTs.
// Expected per-cycle {busy,tx} pushed on acceptance, popped on negedge.
module tb_serial_tx_fsm;

  localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       sel;
  logic       rdy0, tx0, bsy0;
  logic       rdy1, tx1, bsy1;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] e0, e1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_tx_fsm #(.DATA_W(DW), .BIT_CYCLES(4)) u_d4 (
    .clk(clk), .reset(reset), .data_in(data),
    .valid_in(valid & ~sel), .ready_out(rdy0),
    .tx_out(tx0), .busy(bsy0)
  );

  serial_tx_fsm #(.DATA_W(DW), .BIT_CYCLES(1)) u_d1 (
    .clk(clk), .reset(reset), .data_in(data),
    .valid_in(valid & sel), .ready_out(rdy1),
    .tx_out(tx1), .busy(bsy1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic [1:0] e);
    if (s) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic push_frame(input logic s, input logic [7:0] w);
    logic b[$];
    int   bc;
    bc = s ? 1 : 4;
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) b.push_back(w[i]);
    if (PB != 0) b.push_back(^w);
    b.push_back(1'b1);
    foreach (b[k]) repeat (bc) push(s, {1'b1, b[k]});
    push(s, 2'b01);
  endtask

  // Start at a negedge with the DUT idle; return at the idle-cycle negedge.
  task automatic run_frame(input logic s, input logic [7:0] w,
                           input logic keep, input logic [7:0] nxt,
                           input int pulse);
    int fl;
    fl    = (s ? 1 : 4) * (DW + 2 + PB);
    sel   = s;
    data  = w;
    valid = 1'b1;
    @(posedge clk);
    push_frame(s, w);
    for (int i = 1; i <= fl; i++) begin
      @(negedge clk);
      if (i == pulse) begin
        valid = 1'b1;
        data  = 8'hFF;
      end else begin
        valid = keep;
        data  = nxt;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_chk(input logic s, input int n);
    repeat (n) begin
      @(posedge clk);
      push(s, 2'b01);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("d4_tx", tx0, e0[0]);
        chk("d4_busy", bsy0, e0[1]);
        chk("d4_ready", rdy0, !e0[1]);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("d1_tx", tx1, e1[0]);
        chk("d1_busy", bsy1, e1[1]);
        chk("d1_ready", rdy1, !e1[1]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    sel   = 1'b0;
    #2;
    chk("rst_tx", tx0, 1);
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", bsy0, 0);
    chk("rst_d1_ready", rdy1, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_chk(0, 3);

    run_frame(0, 8'hA5, 1'b0, 8'h00, 0);
    idle_chk(0, 2);

    run_frame(0, 8'hA5, 1'b1, 8'h5A, 0);
    run_frame(0, 8'h3C, 1'b0, 8'h00, 0);
    idle_chk(0, 2);

    run_frame(0, 8'h00, 1'b0, 8'h00, 10);
    idle_chk(0, 4);

    sel   = 1'b0;
    data  = 8'hA5;
    valid = 1'b1;
    @(posedge clk);
    push_frame(0, 8'hA5);
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    q0.delete();
    #1;
    chk("abort_tx", tx0, 1);
    chk("abort_ready", rdy0, 1);
    chk("abort_busy", bsy0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_chk(0, 2);
    run_frame(0, 8'h5A, 1'b0, 8'h00, 0);

    run_frame(1, 8'h81, 1'b0, 8'h00, 0);
    idle_chk(1, 2);
    run_frame(1, 8'hC3, 1'b1, 8'h00, 0);
    run_frame(1, 8'h07, 1'b0, 8'h00, 0);
    idle_chk(1, 2);

    run_frame(0, 8'h07, 1'b0, 8'h00, 0);
    idle_chk(0, 2);

    repeat (2) @(negedge clk);
    chk("q_drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
